branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_if.sv | 35 +++
 rtl/branch_resolve.sv | 123 ++++++++++++
 tb/tb_branch_resolve.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Request/result bundle for branch_resolve: the master issues branch requests and
// accepts results, and the slave (branch_resolve) resolves them and reports statistics.
interface branch_resolve_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_valid;
  logic                  o_ready;
  logic [2:0]            i_cond;
  logic [DATA_WIDTH-1:0] i_operand0;
  logic [DATA_WIDTH-1:0] i_operand1;
  logic [DATA_WIDTH-1:0] i_direct_addr;
  logic [DATA_WIDTH-1:0] i_program_addr;
  logic                  i_pred_taken;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_addr;
  logic                  o_taken;
  logic                  o_mispredict;
  logic [CNT_WIDTH-1:0]  o_branch_cnt;
  logic [CNT_WIDTH-1:0]  o_taken_cnt;

  modport master (
    output i_valid, i_cond, i_operand0, i_operand1, i_direct_addr, i_program_addr,
           i_pred_taken, i_flush, i_ready,
    input  o_ready, o_valid, o_addr, o_taken, o_mispredict, o_branch_cnt, o_taken_cnt
  );

  modport slave (
    input  i_valid, i_cond, i_operand0, i_operand1, i_direct_addr, i_program_addr,
           i_pred_taken, i_flush, i_ready,
    output o_ready, o_valid, o_addr, o_taken, o_mispredict, o_branch_cnt, o_taken_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates the condition, selects the target address, flags
// mispredictions and holds a one-entry output register. Define BRANCH_STAT_EN for the counters.
module branch_resolve #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clk,
  input logic          rst_n,
  branch_resolve_if.slave bus
);

  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_LT     = 3'b010,
    COND_GE     = 3'b011,
    COND_LTU    = 3'b100,
    COND_GEU    = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  taken_q, taken_d;
  logic                  mispredict_q, mispredict_d;
  logic                  taken_c;
  logic                  ready_c;
  logic                  accept;

  always_comb begin
    taken_c = 1'b0;
    case (cond_e'(bus.i_cond))
      COND_EQ:     taken_c = (bus.i_operand0 == bus.i_operand1);
      COND_NE:     taken_c = (bus.i_operand0 != bus.i_operand1);
      COND_LT:     taken_c = ($signed(bus.i_operand0) <  $signed(bus.i_operand1));
      COND_GE:     taken_c = ($signed(bus.i_operand0) >= $signed(bus.i_operand1));
      COND_LTU:    taken_c = (bus.i_operand0 <  bus.i_operand1);
      COND_GEU:    taken_c = (bus.i_operand0 >= bus.i_operand1);
      COND_ALWAYS: taken_c = 1'b1;
      COND_NEVER:  taken_c = 1'b0;
      default:     taken_c = 1'b0;
    endcase
  end

  assign ready_c = !valid_q || bus.i_ready;
  assign accept  = bus.i_valid && ready_c && !bus.i_flush;

  // Flush wins over everything; otherwise a new accept keeps the slot full even when the
  // current result retires in the same cycle.
  always_comb begin
    valid_d      = valid_q;
    addr_d       = addr_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    if (bus.i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      addr_d       = taken_c ? bus.i_direct_addr : bus.i_program_addr;
      taken_d      = taken_c;
      mispredict_d = taken_c ^ bus.i_pred_taken;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; payload is reset too because o_addr must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      addr_q       <= '0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign bus.o_ready      = ready_c;
  assign bus.o_valid      = valid_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_taken      = valid_q && taken_q;
  assign bus.o_mispredict = valid_q && mispredict_q;

`ifdef BRANCH_STAT_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 1'b1;
      if (taken_c && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.o_branch_cnt = branch_cnt_q;
  assign bus.o_taken_cnt  = taken_cnt_q;
`else
  assign bus.o_branch_cnt = '0;
  assign bus.o_taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed requests push hand-computed results into
// a queue that a monitor drains as results retire. Counter checks follow BRANCH_STAT_EN.
module tb_branch_resolve;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    string           name;
    logic [DW-1:0]   addr;
    logic            taken;
    logic            mis;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  branch_resolve_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  branch_resolve #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] d, input logic [DW-1:0] p, input logic pr);
    bus.i_cond         = c;
    bus.i_operand0     = a;
    bus.i_operand1     = b;
    bus.i_direct_addr  = d;
    bus.i_program_addr = p;
    bus.i_pred_taken   = pr;
    bus.i_valid        = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input string name, input logic [2:0] c, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] d, input logic [DW-1:0] p,
                      input logic pr, input logic exp_taken);
    exp_t e;
    int   n;
    bit   ok;
    set_req(c, a, b, d, p, pr);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.o_ready && !bus.i_flush) ok = 1'b1;
      else n++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: got no o_ready after %0d cycles, required accept", name, n);
    end else begin
      e.name  = name;
      e.addr  = exp_taken ? d : p;
      e.taken = exp_taken;
      e.mis   = exp_taken ^ pr;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Monitor: every retiring result is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_valid && bus.i_ready && !bus.i_flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got addr 0x%0h with empty queue, required none",
                   bus.o_addr);
        end else begin
          e = sb.pop_front();
          check({e.name, " addr"}, bus.o_addr, e.addr);
          check({e.name, " taken"}, 32'(bus.o_taken), 32'(e.taken));
          check({e.name, " mispredict"}, 32'(bus.o_mispredict), 32'(e.mis));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_cond         = 3'b000;
    bus.i_operand0     = '0;
    bus.i_operand1     = '0;
    bus.i_direct_addr  = '0;
    bus.i_program_addr = '0;
    bus.i_pred_taken   = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_ready        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst o_valid", 32'(bus.o_valid), 0);
    check("rst o_taken", 32'(bus.o_taken), 0);
    check("rst o_mispredict", 32'(bus.o_mispredict), 0);
    check("rst o_addr", bus.o_addr, 0);
    check("rst o_branch_cnt", 32'(bus.o_branch_cnt), 0);
    check("rst o_taken_cnt", 32'(bus.o_taken_cnt), 0);
    check("rst o_ready", 32'(bus.o_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One-cycle latency on the first request.
    send("eq", 3'b000, 32'd5, 32'd5, 32'h100, 32'h004, 1'b0, 1'b1);
    @(negedge clk);
    check("eq latency o_valid", 32'(bus.o_valid), 1);
    check("eq latency o_addr", bus.o_addr, 32'h100);
    @(posedge clk);
    #1;

    // Back-to-back condition coverage.
    send("ne",       3'b001, 32'd5,         32'd6,         32'h200, 32'h008, 1'b1, 1'b1);
    send("lt_s",     3'b010, 32'hFFFF_FFFF, 32'd1,         32'h300, 32'h00C, 1'b0, 1'b1);
    send("ltu",      3'b100, 32'hFFFF_FFFF, 32'd1,         32'h400, 32'h010, 1'b0, 1'b0);
    send("ge_s",     3'b011, 32'hFFFF_FFFF, 32'd1,         32'h500, 32'h014, 1'b1, 1'b0);
    send("geu",      3'b101, 32'hFFFF_FFFF, 32'd1,         32'h600, 32'h018, 1'b1, 1'b1);
    send("ge_s_eq",  3'b011, 32'd7,         32'd7,         32'h700, 32'h01C, 1'b0, 1'b1);
    send("ltu_eq",   3'b100, 32'd7,         32'd7,         32'h800, 32'h020, 1'b0, 1'b0);
    send("lt_s_min", 3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h900, 32'h024, 1'b0, 1'b1);
    send("always",   3'b110, 32'd0,         32'd1,         32'h980, 32'h028, 1'b0, 1'b1);
    send("never",    3'b111, 32'd9,         32'd9,         32'h990, 32'h02C, 1'b1, 1'b0);
    send("eq_miss",  3'b000, 32'd3,         32'd4,         32'h9A0, 32'h030, 1'b1, 1'b0);

    // Idle after the last retire: flags read 0.
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle o_valid", 32'(bus.o_valid), 0);
    check("idle o_taken", 32'(bus.o_taken), 0);
    check("idle o_mispredict", 32'(bus.o_mispredict), 0);
    @(posedge clk);
    #1;

    // Stall: result held and new request blocked while i_ready is low.
    bus.i_ready = 1'b0;
    send("stall_a", 3'b000, 32'd1, 32'd1, 32'hA00, 32'hA04, 1'b1, 1'b1);
    set_req(3'b001, 32'd1, 32'd1, 32'hB00, 32'hB04, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall o_ready", 32'(bus.o_ready), 0);
      check("stall o_valid", 32'(bus.o_valid), 1);
      check("stall o_addr", bus.o_addr, 32'hA00);
      check("stall o_taken", 32'(bus.o_taken), 1);
      check("stall o_mispredict", 32'(bus.o_mispredict), 0);
    end
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    send("stall_b", 3'b001, 32'd1, 32'd1, 32'hB00, 32'hB04, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_b o_valid", 32'(bus.o_valid), 1);
    repeat (2) @(posedge clk);
    #1;

    // Flush with a held result and a valid request: both discarded.
    bus.i_ready = 1'b0;
    send("flush_x", 3'b110, 32'd0, 32'd0, 32'hC00, 32'hC04, 1'b0, 1'b1);
    set_req(3'b110, 32'd0, 32'd0, 32'hC10, 32'hC14, 1'b0);
    bus.i_flush = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush o_valid", 32'(bus.o_valid), 0);
    check("flush o_taken", 32'(bus.o_taken), 0);
    @(negedge clk);
    check("flush no_accept o_valid", 32'(bus.o_valid), 0);
    @(posedge clk);
    #1;

    // Reset asserted in the middle of a stall.
    bus.i_ready = 1'b0;
    send("rst_z", 3'b110, 32'd0, 32'd0, 32'hD00, 32'hD04, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_rst o_valid", 32'(bus.o_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst o_valid", 32'(bus.o_valid), 0);
    check("mid_rst o_taken", 32'(bus.o_taken), 0);
    check("mid_rst o_mispredict", 32'(bus.o_mispredict), 0);
    check("mid_rst o_addr", bus.o_addr, 0);
    check("mid_rst o_branch_cnt", 32'(bus.o_branch_cnt), 0);
    check("mid_rst o_taken_cnt", 32'(bus.o_taken_cnt), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;

    // First accept after reset behaves as from idle; counters start over.
    send("post_rst", 3'b110, 32'd0, 32'd0, 32'hE00, 32'hE04, 1'b0, 1'b1);
`ifdef BRANCH_STAT_EN
    check("cnt1 branch", 32'(bus.o_branch_cnt), 1);
    check("cnt1 taken", 32'(bus.o_taken_cnt), 1);
`else
    check("cnt1 branch", 32'(bus.o_branch_cnt), 0);
    check("cnt1 taken", 32'(bus.o_taken_cnt), 0);
`endif
    @(negedge clk);
    check("post_rst o_valid", 32'(bus.o_valid), 1);
    check("post_rst o_addr", bus.o_addr, 32'hE00);
    @(posedge clk);
    #1;
    send("cnt_never", 3'b111, 32'd0, 32'd0, 32'hE10, 32'hE14, 1'b0, 1'b0);
`ifdef BRANCH_STAT_EN
    check("cnt2 branch", 32'(bus.o_branch_cnt), 2);
    check("cnt2 taken", 32'(bus.o_taken_cnt), 1);
`else
    check("cnt2 branch", 32'(bus.o_branch_cnt), 0);
    check("cnt2 taken", 32'(bus.o_taken_cnt), 0);
`endif
    for (int i = 0; i < 20; i++) begin
      send("cnt_sat", 3'b110, 32'd0, 32'd0, 32'hF00 + 32'(i), 32'h0F0, 1'b1, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef BRANCH_STAT_EN
    check("sat branch_cnt", 32'(bus.o_branch_cnt), 15);
    check("sat taken_cnt", 32'(bus.o_taken_cnt), 15);
`else
    check("sat branch_cnt", 32'(bus.o_branch_cnt), 0);
    check("sat taken_cnt", 32'(bus.o_taken_cnt), 0);
`endif
    check("scoreboard drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
